// File: rtl/st_video_pkg.sv
// rtl/st_video_pkg.sv - shared types, register map and timing helpers for st_video_out
package st_video_pkg;

  typedef enum logic [1:0] {stSYNCING, stWAIT, stACTIVE} stState_t;

  localparam logic [3:0] REG_ENABLE        = 4'd0;
  localparam logic [3:0] REG_CLR_UNDERFLOW = 4'd1;
  localparam logic [3:0] REG_POLARITY      = 4'd2;

  function automatic int calcTotal(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - free-running raster counters with active, raw sync and frame-position strobes
module video_timing_gen
  import st_video_pkg::*;
#(
  parameter int pHRES  = 640,
  parameter int pHFP   = 16,
  parameter int pHSYNC = 96,
  parameter int pHBP   = 48,
  parameter int pVRES  = 480,
  parameter int pVFP   = 10,
  parameter int pVSYNC = 2,
  parameter int pVBP   = 33
) (
  input  logic iCLK,
  input  logic iRESET,
  output logic oACTIVE,
  output logic oHS,
  output logic oVS,
  output logic oFRAME_END,
  output logic oORIGIN,
  output logic oLAST_PIXEL
);

  localparam int HTOTAL = calcTotal(pHRES, pHFP, pHSYNC, pHBP);
  localparam int VTOTAL = calcTotal(pVRES, pVFP, pVSYNC, pVBP);
  localparam int HW = $clog2(HTOTAL);
  localparam int VW = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_LAST       = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_ACT        = HW'(pHRES);
  localparam logic [HW-1:0] H_ACT_LAST   = HW'(pHRES - 1);
  localparam logic [HW-1:0] H_SYNC_START = HW'(pHRES + pHFP);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(pHRES + pHFP + pHSYNC);
  localparam logic [VW-1:0] V_LAST       = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_ACT        = VW'(pVRES);
  localparam logic [VW-1:0] V_ACT_LAST   = VW'(pVRES - 1);
  localparam logic [VW-1:0] V_SYNC_START = VW'(pVRES + pVFP);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(pVRES + pVFP + pVSYNC);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          lineEnd;

  assign lineEnd = (hcnt == H_LAST);

  // vcnt only moves on the line wrap, so VS is naturally line-aligned
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= lineEnd ? '0 : hcnt + 1'b1;
      if (lineEnd) vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end
  end

  assign oACTIVE     = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign oHS         = (hcnt >= H_SYNC_START) && (hcnt < H_SYNC_END);
  assign oVS         = (vcnt >= V_SYNC_START) && (vcnt < V_SYNC_END);
  assign oFRAME_END  = lineEnd && (vcnt == V_LAST);
  assign oORIGIN     = (hcnt == '0) && (vcnt == '0);
  assign oLAST_PIXEL = (hcnt == H_ACT_LAST) && (vcnt == V_ACT_LAST);

endmodule

// File: rtl/st_video_out.sv
// rtl/st_video_out.sv - ST video sink: stream FSM, control registers and registered raster output stage
module st_video_out
  import st_video_pkg::*;
#(
  parameter int pBIT_WIDTH = 16,
  parameter int pHRES  = 640,
  parameter int pHFP   = 16,
  parameter int pHSYNC = 96,
  parameter int pHBP   = 48,
  parameter int pVRES  = 480,
  parameter int pVFP   = 10,
  parameter int pVSYNC = 2,
  parameter int pVBP   = 33
) (
  input  logic                  iCLK,
  input  logic                  iRESET,
  input  logic [3:0]            iAV_ADDRESS,
  input  logic [31:0]           iAV_WRITE_DATA,
  input  logic                  iAV_WRITE,
  input  logic [pBIT_WIDTH-1:0] iST_DATA,
  input  logic                  iST_VALID,
  output logic                  oST_READY,
  input  logic                  iST_SOP,
  input  logic                  iST_EOP,
  output logic [pBIT_WIDTH-1:0] oVID_DATA,
  output logic                  oVID_DE,
  output logic                  oVID_HS,
  output logic                  oVID_VS,
  output logic                  oUNDERFLOW
);

  logic active, hsRaw, vsRaw, frameEnd, origin, lastPix;

  video_timing_gen #(
    .pHRES(pHRES), .pHFP(pHFP), .pHSYNC(pHSYNC), .pHBP(pHBP),
    .pVRES(pVRES), .pVFP(pVFP), .pVSYNC(pVSYNC), .pVBP(pVBP)
  ) uTiming (
    .iCLK        (iCLK),
    .iRESET      (iRESET),
    .oACTIVE     (active),
    .oHS         (hsRaw),
    .oVS         (vsRaw),
    .oFRAME_END  (frameEnd),
    .oORIGIN     (origin),
    .oLAST_PIXEL (lastPix)
  );

  stState_t        state;
  logic            enable;
  logic [1:0]      polarity;
  logic            inActive, beatMissing, lateSop, beatTaken, frameDone, shortFrame, setUf;
  logic            unusedBits;
  logic [pBIT_WIDTH-1:0] pixData;

  assign unusedBits = ^iAV_WRITE_DATA[31:2];

  // Classify what the current active pixel does with the offered beat
  assign inActive    = enable && (state == stACTIVE) && active;
  assign beatMissing = inActive && !iST_VALID;
  assign lateSop     = inActive && iST_VALID && iST_SOP && !origin;
  assign beatTaken   = inActive && iST_VALID && !lateSop;
  assign frameDone   = beatTaken && (iST_EOP || lastPix);
  assign shortFrame  = beatTaken && iST_EOP && !lastPix;
  assign setUf       = beatMissing || lateSop || shortFrame;
  assign pixData     = beatTaken ? iST_DATA : '0;

  always_comb begin
    oST_READY = 1'b0;
    if (!enable)                   oST_READY = 1'b1;
    else if (state == stSYNCING)   oST_READY = !(iST_SOP && iST_VALID);
    else if (state == stACTIVE)    oST_READY = active && !lateSop;
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state      <= stSYNCING;
      enable     <= 1'b1;
      polarity   <= 2'b00;
      oUNDERFLOW <= 1'b0;
      oVID_DATA  <= '0;
      oVID_DE    <= 1'b0;
      oVID_HS    <= 1'b0;
      oVID_VS    <= 1'b0;
    end else begin
      if (!enable) begin
        state <= stSYNCING;
      end else begin
        case (state)
          stSYNCING: if (iST_VALID && iST_SOP) state <= stWAIT;
          stWAIT:    if (frameEnd) state <= stACTIVE;
          stACTIVE: begin
            if (beatMissing || frameDone) state <= stSYNCING;
            else if (lateSop)             state <= stWAIT;
          end
          default:   state <= stSYNCING;
        endcase
      end

      if (iAV_WRITE && iAV_ADDRESS == REG_ENABLE)   enable   <= iAV_WRITE_DATA[0];
      if (iAV_WRITE && iAV_ADDRESS == REG_POLARITY) polarity <= iAV_WRITE_DATA[1:0];
      // a fresh underflow wins over a clear in the same cycle
      if (setUf)                                                oUNDERFLOW <= 1'b1;
      else if (iAV_WRITE && iAV_ADDRESS == REG_CLR_UNDERFLOW)   oUNDERFLOW <= 1'b0;

      oVID_DATA <= pixData;
      oVID_DE   <= active;
      oVID_HS   <= hsRaw ^ polarity[0];
      oVID_VS   <= vsRaw ^ polarity[1];
    end
  end

endmodule
